// File: rtl/fifo_pkg.sv
// Shared types for the FIFO read-side stream: skid-buffer occupancy encoding
// and the stall counter width.
package fifo_pkg;

  typedef enum logic [1:0] {
    OCC0 = 2'd0,
    OCC1 = 2'd1,
    OCC2 = 2'd2
  } occ_state_e;

  localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/fifo_rd_stream_skid_buf2.sv
// skid_buf2: two-entry registered buffer (head/tail) with push, pop and flush.
// The head register always drives the output, so downstream sees registered data.
module skid_buf2
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output occ_state_e       state_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] dout_o
);

  occ_state_e       state_q;
  logic [WIDTH-1:0] hd_q;
  logic [WIDTH-1:0] tl_q;

  // Occupancy FSM; the producer guarantees no push while full.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      state_q <= OCC0;
      hd_q    <= {WIDTH{1'b0}};
      tl_q    <= {WIDTH{1'b0}};
    end else begin
      case (state_q)
        OCC0: begin
          if (push_i) begin
            state_q <= OCC1;
            hd_q    <= din_i;
          end
        end
        OCC1: begin
          if (push_i && !pop_i) begin
            state_q <= OCC2;
            tl_q    <= din_i;
          end else if (pop_i && !push_i) begin
            state_q <= OCC0;
          end else if (push_i && pop_i) begin
            hd_q <= din_i;
          end
        end
        OCC2: begin
          if (pop_i) begin
            state_q <= OCC1;
            hd_q    <= tl_q;
          end
        end
        default: state_q <= OCC0;
      endcase
    end
  end

  assign state_o = state_q;
  assign valid_o = (state_q != OCC0);
  assign dout_o  = hd_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a FWFT FIFO into a burst-framed valid/ready stream.
// Optional FIFO_RD_STREAM_STALL_CNT_EN adds a saturating stall_cnt output.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 4,
  parameter int CW        = $clog2(BURST_LEN) + 1
) (
  input  logic             rd_clk,
  input  logic             rd_reset,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             fifo_rd_en,
  input  logic             flush,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic [CW-1:0]    beat_cnt,
  output logic             busy
`ifdef FIFO_RD_STREAM_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

  occ_state_e    state_s;
  logic          pop_s;
  logic [CW-1:0] beat_cnt_q;

  // rd_en depends only on registered occupancy and inputs, never on m_ready.
  assign fifo_rd_en = !fifo_empty && (state_s != OCC2) && !flush && !rd_reset;
  assign pop_s      = m_valid && m_ready;

  skid_buf2 #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk_i  (rd_clk),
    .rst_i  (rd_reset),
    .flush_i(flush),
    .push_i (fifo_rd_en),
    .pop_i  (pop_s),
    .din_i  (fifo_rd_data),
    .state_o(state_s),
    .valid_o(m_valid),
    .dout_o (m_data)
  );

  // Burst framing: count accepted beats, wrap after the last one.
  always_ff @(posedge rd_clk) begin
    if (rd_reset || flush) begin
      beat_cnt_q <= {CW{1'b0}};
    end else if (pop_s) begin
      if (m_last) begin
        beat_cnt_q <= {CW{1'b0}};
      end else begin
        beat_cnt_q <= beat_cnt_q + CW'(1);
      end
    end
  end

  assign beat_cnt = beat_cnt_q;
  assign m_last   = m_valid && (beat_cnt_q == LAST_BEAT);
  assign busy     = m_valid;

`ifdef FIFO_RD_STREAM_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  // Saturating count of cycles where data waits on downstream.
  always_ff @(posedge rd_clk) begin
    if (rd_reset || flush) begin
      stall_cnt_q <= {STALL_CNT_W{1'b0}};
    end else if (m_valid && !m_ready && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream (WIDTH=8, BURST_LEN=4) with a FWFT FIFO model.
module tb_fifo_rd_stream;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } exp_t;

  logic       rd_clk;
  logic       rd_reset;
  logic       fifo_empty;
  logic [7:0] fifo_rd_data;
  logic       fifo_rd_en;
  logic       flush;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;
  logic [2:0] beat_cnt;
  logic       busy;
`ifdef FIFO_RD_STREAM_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;
  logic [7:0] src_q[$];
  exp_t       exp_q[$];

  fifo_rd_stream #(.WIDTH(8), .BURST_LEN(4)) dut (
    .rd_clk      (rd_clk),
    .rd_reset    (rd_reset),
    .fifo_empty  (fifo_empty),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en  (fifo_rd_en),
    .flush       (flush),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .beat_cnt    (beat_cnt),
    .busy        (busy)
`ifdef FIFO_RD_STREAM_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  initial begin
    rd_clk = 1'b0;
    forever #5 rd_clk = ~rd_clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic load(input logic [7:0] d, input logic l);
    src_q.push_back(d);
    exp_q.push_back('{d, l});
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge rd_clk);
  endtask

  // FWFT FIFO model: head visible while non-empty, popped on edges where rd_en was high.
  initial begin
    logic take;
    fifo_empty   = 1'b1;
    fifo_rd_data = 8'h00;
    forever begin
      @(negedge rd_clk);
      #1;
      fifo_empty   = (src_q.size() == 0);
      fifo_rd_data = (src_q.size() != 0) ? src_q[0] : 8'h00;
      #3;
      take = fifo_rd_en;
      total++;
      if (take && fifo_empty) begin
        bad++;
        $display("FAIL underflow: rd_en=1 with fifo_empty=1");
      end
      @(posedge rd_clk);
      #1;
      if (take && src_q.size() != 0) void'(src_q.pop_front());
      fifo_empty   = (src_q.size() == 0);
      fifo_rd_data = (src_q.size() != 0) ? src_q[0] : 8'h00;
    end
  end

  // Monitor: on every accepted beat, compare against the scoreboard head.
  initial begin
    logic       hold;
    logic [7:0] pd;
    logic       pl;
    exp_t       e;
    hold = 1'b0;
    pd   = 8'h00;
    pl   = 1'b0;
    forever begin
      @(negedge rd_clk);
      #4;
      if (rd_reset) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("stable_data", {24'd0, m_data}, {24'd0, pd});
          chk("stable_last", {31'd0, m_last}, {31'd0, pl});
        end
        if (m_valid && m_ready) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_beat: got %0h expected none", m_data);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", {24'd0, m_data}, {24'd0, e.d});
            chk("beat_last", {31'd0, m_last}, {31'd0, e.l});
          end
        end
        hold = m_valid && !m_ready && !flush;
        pd   = m_data;
        pl   = m_last;
      end
    end
  end

  initial begin
    int rdcnt;
    rd_reset = 1'b1;
    flush    = 1'b0;
    m_ready  = 1'b1;

    // Reset held 3 cycles with a non-empty FIFO, then streaming.
    @(negedge rd_clk);
    for (int i = 0; i < 8; i++) load(8'h10 + 8'(i), (i == 3) || (i == 7));
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge rd_clk);
      #2;
      chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
      chk("rst_valid", {31'd0, m_valid}, 32'd0);
      chk("rst_beat", {29'd0, beat_cnt}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
    end
    @(negedge rd_clk);
    rd_reset = 1'b0;
    #2;
    chk("release_rd_en", {31'd0, fifo_rd_en}, 32'd1);
    chk("release_valid", {31'd0, m_valid}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge rd_clk);
      #2;
      chk("stream_valid", {31'd0, m_valid}, 32'd1);
    end
    @(negedge rd_clk);
    #2;
    chk("stream_drained", {31'd0, m_valid}, 32'd0);
    chk("stream_beat", {29'd0, beat_cnt}, 32'd0);

    // Backpressure: two pops fill the buffer, then rd_en stops.
    @(negedge rd_clk);
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) load(8'h30 + 8'(i), (i == 3) || (i == 7));
    rdcnt = 0;
    for (int i = 0; i < 5; i++) begin
      #2;
      rdcnt += int'(fifo_rd_en);
      @(negedge rd_clk);
    end
    chk("bp_rd_en_count", rdcnt, 32'd2);
    chk("bp_head", {24'd0, m_data}, 32'h30);
    chk("bp_busy", {31'd0, busy}, 32'd1);
    m_ready = 1'b1;
    wait_cyc(12);
    #2;
    chk("bp_drained", {31'd0, m_valid}, 32'd0);
    chk("bp_scoreboard", exp_q.size(), 32'd0);

    // Partial burst: beat count holds while the FIFO is dry.
    @(negedge rd_clk);
    load(8'hA0, 1'b0);
    load(8'hA1, 1'b0);
    wait_cyc(12);
    #2;
    chk("partial_beat", {29'd0, beat_cnt}, 32'd2);
    chk("partial_valid", {31'd0, m_valid}, 32'd0);
    chk("partial_last", {31'd0, m_last}, 32'd0);
    @(negedge rd_clk);
    load(8'hA2, 1'b0);
    load(8'hA3, 1'b1);
    wait_cyc(5);
    #2;
    chk("partial_done_beat", {29'd0, beat_cnt}, 32'd0);

    // Flush in OCC2 with beat_cnt=1; B1,B2 are discarded.
    @(negedge rd_clk);
    load(8'hB0, 1'b0);
    wait_cyc(3);
    #2;
    chk("flush_pre_beat", {29'd0, beat_cnt}, 32'd1);
    @(negedge rd_clk);
    m_ready = 1'b0;
    load(8'hB1, 1'b0);
    load(8'hB2, 1'b0);
    load(8'hB3, 1'b0);
    wait_cyc(2);
    #2;
    chk("occ2_head", {24'd0, m_data}, 32'hB1);
    chk("occ2_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    @(negedge rd_clk);
    flush = 1'b1;
    exp_q.delete(0);
    exp_q.delete(0);
    #2;
    chk("flush_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    @(negedge rd_clk);
    flush   = 1'b0;
    m_ready = 1'b1;
    load(8'hB4, 1'b0);
    load(8'hB5, 1'b0);
    load(8'hB6, 1'b1);
    #2;
    chk("post_flush_valid", {31'd0, m_valid}, 32'd0);
    chk("post_flush_beat", {29'd0, beat_cnt}, 32'd0);
    chk("post_flush_rd_en", {31'd0, fifo_rd_en}, 32'd1);
    wait_cyc(8);
    #2;
    chk("restart_beat", {29'd0, beat_cnt}, 32'd0);
    chk("restart_valid", {31'd0, m_valid}, 32'd0);

`ifdef FIFO_RD_STREAM_STALL_CNT_EN
    // Saturating stall counter, cleared by flush.
    @(negedge rd_clk);
    m_ready = 1'b0;
    load(8'hC0, 1'b0);
    wait_cyc(70002);
    #2;
    chk("stall_sat", {16'd0, stall_cnt}, 32'hFFFF);
    @(negedge rd_clk);
    flush = 1'b1;
    exp_q.delete(0);
    @(negedge rd_clk);
    flush = 1'b0;
    #2;
    chk("stall_clear", {16'd0, stall_cnt}, 32'd0);
`endif

    @(negedge rd_clk);
    #2;
    chk("final_scoreboard", exp_q.size(), 32'd0);
    chk("final_src", src_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
